// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh controller: refresh interval tick, saturating pending count, PALL + AREF burst.
// Define AREF_OVF_STATS_EN to add the lost-tick counter (aref_ovf_cnt) and sticky aref_ovf_flag.
module sdram_aref_ctrl #(
    parameter int CLK_PER_REF = 350,
    parameter int T_RP        = 2,
    parameter int T_RFC       = 7,
    parameter int MAX_PEND    = 8,
    parameter int BURST_MAX   = 4,
    parameter int URGENT_TH   = 6,
    parameter int ADDR_W      = 13,
    localparam int PEND_W     = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_init_end,
    input  logic              aref_en,
    output logic              aref_req,
    output logic              aref_urgent,
    output logic              flag_aref_end,
    output logic [3:0]        aref_cmd,
    output logic [ADDR_W-1:0] aref_addr,
`ifdef AREF_OVF_STATS_EN
    output logic [PEND_W-1:0] aref_pend,
    output logic [7:0]        aref_ovf_cnt,
    output logic              aref_ovf_flag
`else
    output logic [PEND_W-1:0] aref_pend
`endif
);

    localparam int CNT_W   = $clog2(CLK_PER_REF);
    localparam int WAIT_W  = $clog2((T_RFC > T_RP ? T_RFC : T_RP) + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [ADDR_W-1:0] ADDR_ALL_BANKS = ADDR_W'(1) << 10;

    typedef enum logic [2:0] {IDLE, PALL, WAIT_RP, AREF, WAIT_RFC} state_t;

    state_t             state;
    logic [CNT_W-1:0]   ref_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_left;
    logic [BURST_W-1:0] burst_n;
    logic               tick;
    logic               aref_now;
    logic               start_ok;

    assign tick        = flag_init_end && (ref_cnt == CNT_W'(CLK_PER_REF - 1));
    assign aref_now    = (aref_cmd == CMD_AREF);
    assign start_ok    = aref_en && (aref_pend != '0);
    assign burst_n     = (aref_pend > PEND_W'(BURST_MAX)) ? BURST_W'(BURST_MAX) : BURST_W'(aref_pend);
    assign aref_req    = (aref_pend != '0);
    assign aref_urgent = (aref_pend >= PEND_W'(URGENT_TH));
    assign aref_addr   = ADDR_ALL_BANKS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt <= '0;
        else if (!flag_init_end || tick)
            ref_cnt <= '0;
        else
            ref_cnt <= ref_cnt + 1'b1;
    end

    // A tick coinciding with an AREF cycle cancels out, so it is never lost at saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            aref_pend <= '0;
        else if (tick && !aref_now) begin
            if (aref_pend != PEND_W'(MAX_PEND))
                aref_pend <= aref_pend + 1'b1;
        end else if (!tick && aref_now)
            aref_pend <= aref_pend - 1'b1;
    end

`ifdef AREF_OVF_STATS_EN
    logic tick_lost;
    assign tick_lost = tick && !aref_now && (aref_pend == PEND_W'(MAX_PEND));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aref_ovf_cnt  <= '0;
            aref_ovf_flag <= 1'b0;
        end else if (tick_lost) begin
            if (aref_ovf_cnt != '1)
                aref_ovf_cnt <= aref_ovf_cnt + 1'b1;
            aref_ovf_flag <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            aref_cmd      <= CMD_NOP;
            flag_aref_end <= 1'b0;
            wait_cnt      <= '0;
            burst_left    <= '0;
        end else begin
            aref_cmd      <= CMD_NOP;
            flag_aref_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= PALL;
                        aref_cmd   <= CMD_PALL;
                        burst_left <= burst_n;
                    end
                end
                PALL: begin
                    if (T_RP == 1) begin
                        state    <= AREF;
                        aref_cmd <= CMD_AREF;
                    end else begin
                        state    <= WAIT_RP;
                        wait_cnt <= WAIT_W'(T_RP - 1);
                    end
                end
                WAIT_RP: begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        state    <= AREF;
                        aref_cmd <= CMD_AREF;
                    end else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                AREF: begin
                    state         <= WAIT_RFC;
                    wait_cnt      <= WAIT_W'(T_RFC - 1);
                    burst_left    <= burst_left - 1'b1;
                    flag_aref_end <= (T_RFC == 2) && (burst_left == BURST_W'(1));
                end
                WAIT_RFC: begin
                    // The final wait cycle doubles as IDLE so a new grant can start the next PALL at once.
                    if (wait_cnt == WAIT_W'(1)) begin
                        if (burst_left != '0) begin
                            state    <= AREF;
                            aref_cmd <= CMD_AREF;
                        end else if (start_ok) begin
                            state      <= PALL;
                            aref_cmd   <= CMD_PALL;
                            burst_left <= burst_n;
                        end else
                            state <= IDLE;
                    end else begin
                        wait_cnt      <= wait_cnt - 1'b1;
                        flag_aref_end <= (wait_cnt == WAIT_W'(2)) && (burst_left == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Self-checking bench for sdram_aref_ctrl: directed vector table, hand sequences, random vs. schedule model.
module tb_sdram_aref_ctrl;

    localparam int CPR = 20, TRP = 2, TRFC = 7, MP = 8, BM = 4, UTH = 6, AW = 13;
    localparam logic [3:0] NOP = 4'b0111, PALL = 4'b0010, AREF = 4'b0001;

    logic clk = 1'b0, rst_n = 1'b0, flag_init_end = 1'b0, aref_en = 1'b0, en_off = 1'b0;
    logic aref_req, aref_urgent, flag_aref_end;
    logic [3:0] aref_cmd, aref_pend;
    logic [AW-1:0] aref_addr;
    logic d_req, d_urg, d_flag;
    logic [3:0] d_cmd, d_pend;
    logic [12:0] d_addr;
`ifdef AREF_OVF_STATS_EN
    logic [7:0] aref_ovf_cnt, d_ovf_cnt;
    logic aref_ovf_flag, d_ovf_flag;
`endif

    sdram_aref_ctrl #(.CLK_PER_REF(CPR), .T_RP(TRP), .T_RFC(TRFC), .MAX_PEND(MP),
                      .BURST_MAX(BM), .URGENT_TH(UTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end), .aref_en(aref_en),
        .aref_req(aref_req), .aref_urgent(aref_urgent), .flag_aref_end(flag_aref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
`ifdef AREF_OVF_STATS_EN
        .aref_ovf_cnt(aref_ovf_cnt), .aref_ovf_flag(aref_ovf_flag),
`endif
        .aref_pend(aref_pend));

    sdram_aref_ctrl dut_def (
        .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end), .aref_en(en_off),
        .aref_req(d_req), .aref_urgent(d_urg), .flag_aref_end(d_flag),
        .aref_cmd(d_cmd), .aref_addr(d_addr),
`ifdef AREF_OVF_STATS_EN
        .aref_ovf_cnt(d_ovf_cnt), .aref_ovf_flag(d_ovf_flag),
`endif
        .aref_pend(d_pend));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: on a grant the whole command schedule is laid out in a queue.
    typedef struct {logic [3:0] cmd; bit flag;} slot_t;
    slot_t m_q[$];
    int m_pend, m_icnt, m_ovf;
    bit m_ovf_flag, m_flag;
    logic [3:0] m_cmd;

    function automatic void model_reset();
        m_q.delete();
        m_pend = 0; m_icnt = 0; m_ovf = 0; m_ovf_flag = 0;
        m_cmd = NOP; m_flag = 0;
    endfunction

    function automatic void model_step();
        bit tk;
        int old, n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk = flag_init_end && (m_icnt == CPR - 1);
        old = m_pend;
        m_icnt = flag_init_end ? (m_icnt + 1) % CPR : 0;
        if (m_cmd == AREF) m_pend--;
        if (tk) begin
            if (m_pend < MP) m_pend++;
            else begin
                if (m_ovf < 255) m_ovf++;
                m_ovf_flag = 1;
            end
        end
        if (m_q.size() != 0) void'(m_q.pop_front());
        if (m_q.size() == 0 && aref_en && old != 0) begin
            n = (old < BM) ? old : BM;
            m_q.push_back('{PALL, 1'b0});
            for (int k = 1; k < TRP; k++) m_q.push_back('{NOP, 1'b0});
            for (int a = 0; a < n; a++) begin
                m_q.push_back('{AREF, 1'b0});
                for (int k = 1; k < TRFC; k++) m_q.push_back('{NOP, bit'(a == n - 1 && k == TRFC - 1)});
            end
        end
        if (m_q.size() != 0) begin
            m_cmd = m_q[0].cmd; m_flag = m_q[0].flag;
        end else begin
            m_cmd = NOP; m_flag = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic void check_model();
        chk("rnd_cmd", int'(aref_cmd), int'(m_cmd));
        chk("rnd_flag_end", int'(flag_aref_end), int'(m_flag));
        chk("rnd_pend", int'(aref_pend), m_pend);
        chk("rnd_req", int'(aref_req), int'(m_pend != 0));
        chk("rnd_urgent", int'(aref_urgent), int'(m_pend >= UTH));
        chk("rnd_addr", int'(aref_addr), 'h400);
`ifdef AREF_OVF_STATS_EN
        chk("rnd_ovf_cnt", int'(aref_ovf_cnt), m_ovf);
        chk("rnd_ovf_flag", int'(aref_ovf_flag), int'(m_ovf_flag));
`endif
    endfunction

    function automatic void check_reset(string tag);
        chk({tag, "_cmd"}, int'(aref_cmd), int'(NOP));
        chk({tag, "_pend"}, int'(aref_pend), 0);
        chk({tag, "_req"}, int'(aref_req), 0);
        chk({tag, "_urgent"}, int'(aref_urgent), 0);
        chk({tag, "_flag_end"}, int'(flag_aref_end), 0);
        chk({tag, "_addr"}, int'(aref_addr), 'h400);
`ifdef AREF_OVF_STATS_EN
        chk({tag, "_ovf_cnt"}, int'(aref_ovf_cnt), 0);
        chk({tag, "_ovf_flag"}, int'(aref_ovf_flag), 0);
`endif
    endfunction

    typedef struct {int adv; bit init; bit en; logic [3:0] cmd; int pend; bit req; bit urg; bit flag;} vec_t;
    vec_t tbl[$];

    initial begin
        int busy;
        // Cycle numbers (Pk) count rising edges since reset release; counter wraps every 20.
        tbl.push_back('{19, 1, 0, NOP,  0, 0, 0, 0});  // P19: one edge before first tick
        tbl.push_back('{1,  1, 0, NOP,  1, 1, 0, 0});  // P20: first tick
        tbl.push_back('{40, 1, 0, NOP,  3, 1, 0, 0});  // P60
        tbl.push_back('{1,  1, 1, PALL, 3, 1, 0, 0});  // P61: grant, burst of 3
        tbl.push_back('{1,  1, 0, NOP,  3, 1, 0, 0});
        tbl.push_back('{1,  1, 0, AREF, 3, 1, 0, 0});  // t+2
        tbl.push_back('{1,  1, 0, NOP,  2, 1, 0, 0});
        tbl.push_back('{6,  1, 0, AREF, 2, 1, 0, 0});  // t+9
        tbl.push_back('{7,  1, 0, AREF, 1, 1, 0, 0});  // t+16
        tbl.push_back('{1,  1, 0, NOP,  0, 0, 0, 0});
        tbl.push_back('{2,  1, 0, NOP,  1, 1, 0, 0});  // P80 tick mid-sequence
        tbl.push_back('{3,  1, 0, NOP,  1, 1, 0, 1});  // t+22 flag_aref_end
        tbl.push_back('{1,  1, 0, NOP,  1, 1, 0, 0});
        tbl.push_back('{96, 1, 0, NOP,  6, 1, 1, 0});  // P180: pending 6, urgent
        tbl.push_back('{1,  1, 1, PALL, 6, 1, 1, 0});  // burst capped at 4
        tbl.push_back('{2,  1, 0, AREF, 6, 1, 1, 0});
        tbl.push_back('{1,  1, 0, NOP,  5, 1, 0, 0});  // urgent drops below 6
        tbl.push_back('{20, 1, 0, AREF, 4, 1, 0, 0});  // 4th AREF
        tbl.push_back('{1,  1, 0, NOP,  3, 1, 0, 0});
        tbl.push_back('{5,  1, 0, NOP,  3, 1, 0, 1});
        tbl.push_back('{1,  1, 0, NOP,  3, 1, 0, 0});  // no 5th AREF
        tbl.push_back('{25, 1, 0, NOP,  4, 1, 0, 0});  // P236
        tbl.push_back('{1,  1, 1, PALL, 4, 1, 0, 0});  // P237
        tbl.push_back('{2,  1, 0, AREF, 4, 1, 0, 0});  // AREF cycle ends on tick edge P240
        tbl.push_back('{1,  1, 0, NOP,  4, 1, 0, 0});  // net zero
        tbl.push_back('{7,  1, 0, NOP,  3, 1, 0, 0});
        tbl.push_back('{19, 1, 0, NOP,  2, 1, 0, 1});  // P266 flag_aref_end

        model_reset();
        repeat (2) step();
        check_reset("rst0");

        // Default-parameter instance: request after exactly 350 clocks.
        rst_n = 1; flag_init_end = 1;
        repeat (349) step();
        chk("def_req_349", int'(d_req), 0);
        step();
        chk("def_req_350", int'(d_req), 1);
        chk("def_pend_350", int'(d_pend), 1);
        chk("def_urgent", int'(d_urg), 0);
        chk("def_cmd", int'(d_cmd), int'(NOP));
        chk("def_flag_end", int'(d_flag), 0);
        chk("def_addr", int'(d_addr), 'h400);
`ifdef AREF_OVF_STATS_EN
        chk("def_ovf_cnt", int'(d_ovf_cnt), 0);
        chk("def_ovf_flag", int'(d_ovf_flag), 0);
`endif

        rst_n = 0; flag_init_end = 0;
        model_reset();
        #1;
        check_reset("rst1");
        step();
        rst_n = 1;

        foreach (tbl[i]) begin
            flag_init_end = tbl[i].init;
            aref_en = tbl[i].en;
            repeat (tbl[i].adv) step();
            chk($sformatf("vec%0d_cmd", i), int'(aref_cmd), int'(tbl[i].cmd));
            chk($sformatf("vec%0d_pend", i), int'(aref_pend), tbl[i].pend);
            chk($sformatf("vec%0d_req", i), int'(aref_req), int'(tbl[i].req));
            chk($sformatf("vec%0d_urgent", i), int'(aref_urgent), int'(tbl[i].urg));
            chk($sformatf("vec%0d_flag_end", i), int'(flag_aref_end), int'(tbl[i].flag));
            chk($sformatf("vec%0d_addr", i), int'(aref_addr), 'h400);
        end

        // Back-to-back grant, then reset during WAIT_RFC of the second AREF.
        aref_en = 1;
        step();
        chk("b2b_pall", int'(aref_cmd), int'(PALL));
        aref_en = 0;
        repeat (9) step();
        chk("second_aref", int'(aref_cmd), int'(AREF));
        step();
        rst_n = 0;
        model_reset();
        #1;
        check_reset("rst_mid");
        step();
        rst_n = 1; aref_en = 1;
        busy = 0;
        for (int c = 0; c < 19; c++) begin
            step();
            if (aref_cmd != NOP) busy++;
        end
        chk("post_rst_idle_cmds", busy, 0);
        chk("post_rst_pend", int'(aref_pend), 0);
        aref_en = 0;
        step();
        chk("post_rst_tick", int'(aref_pend), 1);

        // Nine more ticks with no grant: saturates at 8, two ticks lost.
        repeat (180) step();
        chk("sat_pend", int'(aref_pend), MP);
        chk("sat_urgent", int'(aref_urgent), 1);
`ifdef AREF_OVF_STATS_EN
        chk("sat_ovf_cnt", int'(aref_ovf_cnt), 2);
        chk("sat_ovf_flag", int'(aref_ovf_flag), 1);
`endif

        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 199) == 0) flag_init_end = !flag_init_end;
            aref_en = ($urandom_range(0, 99) < ((i < 2000) ? 3 : 40));
            step();
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
